iterative_mdu: RTL

Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU and executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. It accepts one operation per start pulse, holds `stall_o` so the core freezes PC and register write-back, and returns a 32-bit result with a one-cycle `done_o` pulse. It uses a shift-add multiplier and a restoring divider sharing one adder and one counter.

---
 rtl/iterative_mdu.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/iterative_mdu.sv
// iterative_mdu: multi-cycle RV32M multiply/divide unit.
// Shift-add multiplier and restoring divider share one adder and one
// iteration counter. The core is frozen via stall_o while an op is running.
// Optional build macro MDU_EARLY_OUT_EN: divide-by-zero, signed overflow
// and multiply-by-zero skip CALC/FIX and finish straight from PREP.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start_i; operands and sign flags latched on start
// PREP   | clear accumulator/remainder/counter, flag special divides
// CALC   | one multiply or divide iteration per cycle, DATA_WIDTH cycles
// FIX    | sign correction and special-case overrides, load result_o
// DONE   | done_o high for one cycle, start_i ignored
module iterative_mdu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q;
  logic [2:0]      f3_q;
  logic            sgn1_q, sgn2_q;
  logic [W-1:0]    opa_q;     // multiplicand, or dividend shifting into quotient
  logic [W-1:0]    opb_q;     // multiplier (shifts right), or divisor
  logic [W-1:0]    rs1_q;     // raw rs1, the remainder for divide-by-zero
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    rem_q;
  logic [CW-1:0]   cnt_q;
  logic            div_zero_q, div_ovf_q;

  logic            sgn1_in, sgn2_in;
  logic [W-1:0]    mag1_in, mag2_in;
  logic            dz_c, ovf_c;
  logic [W+1:0]    add_a, add_b, add_sum;
  logic            add_sub;
  logic [2*W-1:0]  mul_prod;
  logic [W-1:0]    fix_res;

  // Sign flags and magnitudes of the incoming operands for the IDLE latch
  always_comb begin
    sgn1_in = rs1_data_i[W-1] & ((funct3_i == 3'b001) | (funct3_i == 3'b010) |
                                 (funct3_i == 3'b100) | (funct3_i == 3'b110));
    sgn2_in = rs2_data_i[W-1] & ((funct3_i == 3'b001) | (funct3_i == 3'b100) |
                                 (funct3_i == 3'b110));
    mag1_in = sgn1_in ? -rs1_data_i : rs1_data_i;
    mag2_in = sgn2_in ? -rs2_data_i : rs2_data_i;
  end

  // Special divide cases, judged from the latched magnitudes and signs
  always_comb begin
    dz_c  = f3_q[2] & (opb_q == '0);
    ovf_c = f3_q[2] & ~f3_q[0] & sgn1_q & sgn2_q &
            (opa_q == MIN_NEG) & (opb_q == W'(1));
  end

  // Shared adder: accumulate for multiply, trial-subtract for divide
  always_comb begin
    add_sub = f3_q[2];
    if (f3_q[2]) begin
      add_a = {1'b0, rem_q, opa_q[W-1]};
      add_b = {2'b00, opb_q};
    end else begin
      add_a = {2'b00, acc_q[2*W-1:W]};
      add_b = {2'b00, opa_q};
    end
    add_sum = add_a + (add_sub ? ~add_b : add_b) + {{(W+1){1'b0}}, add_sub};
  end

  // Final sign correction and special-case overrides
  always_comb begin
    mul_prod = (sgn1_q ^ sgn2_q) ? -acc_q : acc_q;
    fix_res  = '0;
    if (!f3_q[2]) begin
      fix_res = (f3_q[1:0] == 2'b00) ? mul_prod[W-1:0] : mul_prod[2*W-1:W];
    end else if (!f3_q[1]) begin
      if (div_zero_q)     fix_res = '1;
      else if (div_ovf_q) fix_res = MIN_NEG;
      else                fix_res = (sgn1_q ^ sgn2_q) ? -opa_q : opa_q;
    end else begin
      if (div_zero_q)     fix_res = rs1_q;
      else if (div_ovf_q) fix_res = '0;
      else                fix_res = sgn1_q ? -rem_q : rem_q;
    end
  end

`ifdef MDU_EARLY_OUT_EN
  logic         fast_c;
  logic [W-1:0] ovr_val;

  // Early-out detection and the result it finishes with
  always_comb begin
    fast_c  = dz_c | ovf_c | (~f3_q[2] & ((opa_q == '0) | (opb_q == '0)));
    ovr_val = '0;
    if (dz_c)       ovr_val = f3_q[1] ? rs1_q : '1;
    else if (ovf_c) ovr_val = f3_q[1] ? '0 : MIN_NEG;
  end
`endif

  // Freeze the core from the start request until DONE is entered
  assign stall_o = (start_i & (state_q == S_IDLE)) | (state_q == S_PREP) |
                   (state_q == S_CALC) | (state_q == S_FIX);

  // Sequencer and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      f3_q       <= '0;
      sgn1_q     <= 1'b0;
      sgn2_q     <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      rs1_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_PREP;
            busy_o  <= 1'b1;
            f3_q    <= funct3_i;
            sgn1_q  <= sgn1_in;
            sgn2_q  <= sgn2_in;
            opa_q   <= mag1_in;
            opb_q   <= mag2_in;
            rs1_q   <= rs1_data_i;
          end
        end
        S_PREP: begin
          acc_q      <= '0;
          rem_q      <= '0;
          cnt_q      <= '0;
          div_zero_q <= dz_c;
          div_ovf_q  <= ovf_c;
`ifdef MDU_EARLY_OUT_EN
          if (fast_c) begin
            result_o <= ovr_val;
            done_o   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q  <= S_CALC;
          end
`else
          state_q    <= S_CALC;
`endif
        end
        S_CALC: begin
          if (!f3_q[2]) begin
            if (opb_q[0]) acc_q <= {add_sum[W:0], acc_q[W-1:1]};
            else          acc_q <= {1'b0, acc_q[2*W-1:1]};
            opb_q <= {1'b0, opb_q[W-1:1]};
          end else if (!add_sum[W+1]) begin
            rem_q <= add_sum[W-1:0];
            opa_q <= {opa_q[W-2:0], 1'b1};
          end else begin
            rem_q <= {rem_q[W-2:0], opa_q[W-1]};
            opa_q <= {opa_q[W-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          result_o <= fix_res;
          done_o   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule
